// File: rtl/nibble_serial_add_arbiter.sv
// nibble_serial_add_arbiter
//   Two requesters share a single 4-bit ripple adder. Operands are added
//   nibble-serially, least significant nibble first, through an internal
//   carry register; the result is returned on a valid/ready channel tagged
//   with the owning requester. Requesters are granted round-robin.
//
//   Optional feature: define SUBTRACT_EN to add per-requester sub inputs
//   (req0_sub, req1_sub). When sub=1 the b nibbles are inverted into the
//   adder and the initial carry is forced to 1, giving a-b; res_carry is
//   then the "no borrow" flag (a >= b unsigned).

// 4-bit ripple-carry full adder; the only arithmetic element in the block.
module four_bit_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  // Ripple the carry through four full-adder cells.
  // NOTE: every variable written in an always_comb is given a value on every
  // path (here by construction, elsewhere by a default first) so no latch is
  // inferred.
  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module nibble_serial_add_arbiter #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
`ifdef SUBTRACT_EN
  input  logic             req0_sub,
`endif

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef SUBTRACT_EN
  input  logic             req1_sub,
`endif

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  // Index only ever counts 0..NIBBLES-1; it never needs to wrap.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             carry_q;
  logic             last_grant;
`ifdef SUBTRACT_EN
  logic             sub_q;
`endif

  logic             grant0;
  logic             grant1;
  logic             take0;
  logic             take1;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [IW+1:0]    nib_base;

  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that was not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Ready is only offered while idle, so at most one can be high.
  assign req0_ready = (state == S_IDLE) & grant0;
  assign req1_ready = (state == S_IDLE) & grant1;
  assign take0      = req0_valid & req0_ready;
  assign take1      = req1_valid & req1_ready;

  // Select the current nibble of each captured operand for the shared adder.
  always_comb begin
    nib_base = {idx, 2'b00};
    a_nib    = a_q[nib_base +: 4];
    b_nib    = b_q[nib_base +: 4];
`ifdef SUBTRACT_EN
    // Two's-complement subtraction: invert b here, initial carry is 1.
    if (sub_q) b_nib = ~b_nib;
`endif
  end

  four_bit_full_adder u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Control FSM and datapath registers: accept, run one nibble per cycle,
  // then hold the result until the consumer takes it.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are cleared too; they are few flops and a
      // known value keeps reset-time behaviour fully deterministic.
      state      <= S_IDLE;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_id     <= 1'b0;
      busy       <= 1'b0;
      idx        <= '0;
      carry_q    <= 1'b0;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
`ifdef SUBTRACT_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (take0 | take1) begin
            a_q        <= take1 ? req1_a : req0_a;
            b_q        <= take1 ? req1_b : req0_b;
`ifdef SUBTRACT_EN
            sub_q      <= take1 ? req1_sub : req0_sub;
            if (take1 ? req1_sub : req0_sub)
              carry_q  <= 1'b1;
            else
              carry_q  <= take1 ? req1_cin : req0_cin;
`else
            carry_q    <= take1 ? req1_cin : req0_cin;
`endif
            res_id     <= take1;
            last_grant <= take1;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end

        S_RUN: begin
          res_sum[nib_base +: 4] <= nib_sum;
          carry_q                <= nib_cout;
          if (idx == LAST_IDX) begin
            res_carry <= nib_cout;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// Self-checking bench for nibble_serial_add_arbiter (NIBBLES=4).
// Table-driven directed vectors, hand-written multi-cycle sequences
// (alternating grants, result stall, mid-operation reset) and randomized
// traffic compared with a plain-arithmetic reference model.
// Define SUBTRACT_EN to exercise the subtract option.
module tb_nibble_serial_add_arbiter;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_carry, res_id, busy;
  logic [W-1:0] res_sum;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_grant_m;  // reference: requester served most recently

  always #5 clk = ~clk;

  nibble_serial_add_arbiter #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef SUBTRACT_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef SUBTRACT_EN
    .req1_sub   (req1_sub),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .busy       (busy)
  );

  typedef struct {
    bit           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {carry, sum}. Subtraction reports "no borrow" as carry.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {a >= b, W'(a - b)};
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
  endfunction

  function automatic logic rand_sub();
`ifdef SUBTRACT_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  // One complete transaction from the current negedge: raise the chosen
  // valids, check grant, latency, result and stall stability, then drain.
  task automatic transact(input bit v0, input bit v1, input int stall, input string tag,
                          output logic [W-1:0] got_sum, output logic got_carry);
    bit           exp_id;
    bit           seen;
    int           lat;
    logic [W:0]   exp_res;
    exp_id     = (v0 && v1) ? ~last_grant_m : (v0 ? 1'b0 : 1'b1);
    req0_valid = v0;
    req1_valid = v1;
    got_sum    = 'x;
    got_carry  = 1'bx;
    #1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req0_ready | req1_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!seen) begin
      check({tag, "_grant_timeout"}, 1'b0, 1'b1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    check({tag, "_ready_both"}, req0_ready & req1_ready, 1'b0);
    check({tag, "_grant"}, req1_ready, exp_id);
    exp_res = exp_id ? model(req1_a, req1_b, req1_cin, req1_sub)
                     : model(req0_a, req0_b, req0_cin, req0_sub);
    last_grant_m = exp_id;
    @(negedge clk);
    // Operands must be captured only at the handshake edge.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    req0_sub = rand_sub(); req1_sub = rand_sub();
    #1;
    check({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, N);
    check({tag, "_sum"}, res_sum, exp_res[W-1:0]);
    check({tag, "_carry"}, res_carry, exp_res[W]);
    check({tag, "_id"}, res_id, exp_id);
    got_sum   = res_sum;
    got_carry = res_carry;
    for (int s = 0; s < stall; s++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready  = 1'b0;
      @(negedge clk); #1;
      check({tag, "_stall_valid"}, res_valid, 1'b1);
      check({tag, "_stall_sum"}, res_sum, exp_res[W-1:0]);
      check({tag, "_stall_id"}, res_id, exp_id);
      check({tag, "_stall_ready"}, {req0_ready, req1_ready}, 2'b00);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check({tag, "_drain_valid"}, res_valid, 1'b0);
    check({tag, "_drain_busy"}, busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] gs;
    logic         gc;
    int           g_id[$];
    int           g_cyc[$];
    bit           both_high;
    logic [W:0]   e3;

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
    last_grant_m = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", {res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready},
          '0);

    // Directed vectors.
    vecs.push_back('{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
    vecs.push_back('{0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
`ifdef SUBTRACT_EN
    vecs.push_back('{0, 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1});
    vecs.push_back('{1, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0});
    vecs.push_back('{0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif
    foreach (vecs[i]) begin
      if (vecs[i].id) begin
        req1_a = vecs[i].a; req1_b = vecs[i].b; req1_cin = vecs[i].cin; req1_sub = vecs[i].sub;
      end else begin
        req0_a = vecs[i].a; req0_b = vecs[i].b; req0_cin = vecs[i].cin; req0_sub = vecs[i].sub;
      end
      transact(!vecs[i].id, vecs[i].id, 0, $sformatf("vec%0d", i), gs, gc);
      check($sformatf("vec%0d_tbl_sum", i), gs, vecs[i].exp_sum);
      check($sformatf("vec%0d_tbl_carry", i), gc, vecs[i].exp_carry);
    end

    // Result held for five cycles while both requesters wait.
    req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b1; req0_sub = 1'b0;
    transact(1'b1, 1'b0, 5, "stall", gs, gc);
    check("stall_tbl_sum", gs, 16'hBCDF);

    // Both requesters valid from reset: grants alternate every 6 cycles.
    rst = 1'b1;
    req0_a = 16'h0102; req0_b = 16'h0304; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_a = 16'hF000; req1_b = 16'h1001; req1_cin = 1'b1; req1_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    both_high = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_high = 1'b1;
      if (req0_ready || req1_ready) begin
        g_id.push_back(int'(req1_ready));
        g_cyc.push_back(cyc);
      end
      if (res_valid) begin
        e3 = res_id ? model(16'hF000, 16'h1001, 1'b1, 1'b0) : model(16'h0102, 16'h0304, 1'b0, 1'b0);
        check($sformatf("rr_sum_c%0d", cyc), {res_carry, res_sum}, e3);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_ready_both", both_high, 1'b0);
    check("rr_grant_count", g_id.size(), 5);
    for (int i = 0; i < g_id.size(); i++) begin
      check($sformatf("rr_grant%0d", i), g_id[i], i % 2);
      if (i > 0) check($sformatf("rr_gap%0d", i), g_cyc[i] - g_cyc[i-1], N + 2);
    end
    for (int c = 0; c < 20 && (busy || res_valid); c++) @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("rr_drained", busy, 1'b0);
    if (g_id.size() > 0) last_grant_m = g_id[g_id.size() - 1][0];

    // Reset while the third nibble is pending; a queued req0 follows.
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("rrst_pre_ready", req0_ready, 1'b1);
    repeat (3) @(negedge clk);  // accept edge, then nibbles 0 and 1
    #1;
    check("rrst_running", {busy, res_valid}, 2'b10);
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("rrst_busy", busy, 1'b0);
    check("rrst_valid", res_valid, 1'b0);
    rst = 1'b0;
    last_grant_m = 1'b1;
    #1;
    check("rrst_first_idle_ready", req0_ready, 1'b1);
    transact(1'b1, 1'b0, 0, "rrst_op", gs, gc);
    check("rrst_tbl_sum", {gc, gs}, {1'b0, 16'h8001});

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      bit v0, v1;
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      req0_sub = rand_sub(); req1_sub = rand_sub();
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      transact(v0, v1, $urandom_range(0, 3), $sformatf("rnd%0d", it), gs, gc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
